// File: rtl/multi_channel_interval_timer_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_channel_interval_timer_if
//  Brief    : Avalon-MM slave bus and interrupt outputs of the interval timer
//  Revision : 1.0
// ============================================================================
interface multi_channel_interval_timer_if #(
   parameter int NUM_CH = 4,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              irq;
   logic [NUM_CH-1:0] irq_vec;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq, irq_vec
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq, irq_vec
   );
endinterface
`default_nettype wire

// File: rtl/multi_channel_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_channel_interval_timer
//  Brief    : NUM_CH down-counting interval timers with a shared prescaler,
//             one-shot/continuous modes, snapshot capture and maskable irqs
//  Revision : 1.0
// ============================================================================
module multi_channel_interval_timer #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 32,
   parameter int ADDR_W     = 5,
   parameter int PERIOD_RST = 49999
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   multi_channel_interval_timer_if.slave bus
);

   localparam int                CH_W        = ADDR_W - 2;
   localparam logic [ADDR_W-1:0] c_A_PRESC   = ADDR_W'(4 * NUM_CH);
   localparam logic [ADDR_W-1:0] c_A_PEND    = ADDR_W'(4 * NUM_CH + 1);
   localparam logic [1:0]        c_OFF_STAT  = 2'd0;
   localparam logic [1:0]        c_OFF_CTRL  = 2'd1;
   localparam logic [1:0]        c_OFF_PER   = 2'd2;
   localparam logic [1:0]        c_OFF_SNAP  = 2'd3;
   localparam logic [CNT_W-1:0]  c_RST_VAL   = CNT_W'(PERIOD_RST);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } ch_state_e;

   ch_state_e         state_q  [NUM_CH];
   ch_state_e         state_d  [NUM_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  period_q [NUM_CH];
   logic [CNT_W-1:0]  period_d [NUM_CH];
   logic [CNT_W-1:0]  snap_q   [NUM_CH];
   logic [CNT_W-1:0]  snap_d   [NUM_CH];
   logic [NUM_CH-1:0] to_q, to_d, ito_q, ito_d, cont_q, cont_d, load_q, load_d;
   logic [15:0]       presc_q, presc_d, pcnt_q, pcnt_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              w_wr, w_presc_wr, w_tick;
   logic [CH_W-1:0]   w_ch;
   logic [1:0]        w_off;
   logic [CNT_W-1:0]  w_wdata;
   logic [NUM_CH-1:0] w_hit, w_tmo;

   assign w_wr       = bus.chipselect & ~bus.write_n;
   assign w_ch       = bus.address[ADDR_W-1:2];
   assign w_off      = bus.address[1:0];
   assign w_wdata    = bus.writedata[CNT_W-1:0];
   assign w_presc_wr = w_wr && (bus.address == c_A_PRESC);
   // A PRESCALE write restarts the prescaler, so it never ticks in that cycle
   assign w_tick     = (pcnt_q == 16'd0) && !w_presc_wr;

   // Per-channel write select and timeout event
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign w_hit[c] = w_wr && (w_ch == CH_W'(c));
      assign w_tmo[c] = (state_q[c] == S_RUN) && w_tick && (cnt_q[c] == '0);
   end

   assign bus.irq_vec  = to_q & ito_q;
   assign bus.irq      = |(to_q & ito_q);
   assign bus.readdata = rdata_q;

   // Prescaler next state: reload on tick or on PRESCALE write, else count down
   always_comb begin
      presc_d = presc_q;
      pcnt_d  = pcnt_q;
      if (w_presc_wr) begin
         presc_d = bus.writedata[15:0];
         pcnt_d  = bus.writedata[15:0];
      end else if (pcnt_q == 16'd0) begin
         pcnt_d  = presc_q;
      end else begin
         pcnt_d  = pcnt_q - 16'd1;
      end
   end

   // Channel next state: clear-then-event ordering lets a timeout beat a STATUS
   // write, and bus commands override the one-shot auto-stop
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      snap_d   = snap_q;
      to_d     = to_q;
      ito_d    = ito_q;
      cont_d   = cont_q;
      load_d   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_hit[c] && (w_off == c_OFF_STAT)) begin
            to_d[c] = 1'b0;
         end
         // Deferred counter load one cycle after a PERIOD write
         if (load_q[c]) begin
            cnt_d[c] = period_q[c];
         end
         if ((state_q[c] == S_RUN) && w_tick) begin
            if (w_tmo[c]) begin
               cnt_d[c] = period_q[c];
               to_d[c]  = 1'b1;
               if (!cont_q[c]) begin
                  state_d[c] = S_IDLE;
               end
            end else begin
               cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
         end
         if (w_hit[c]) begin
            case (w_off)
               c_OFF_CTRL: begin
                  ito_d[c]  = bus.writedata[0];
                  cont_d[c] = bus.writedata[1];
                  if (bus.writedata[3]) begin
                     state_d[c] = S_IDLE;
                  end else if (bus.writedata[2]) begin
                     state_d[c] = S_RUN;
                  end
               end
               c_OFF_PER: begin
                  period_d[c] = w_wdata;
                  state_d[c]  = S_IDLE;
                  load_d[c]   = 1'b1;
               end
               c_OFF_SNAP: begin
                  snap_d[c] = cnt_q[c];
               end
               default: ;
            endcase
         end
      end
   end

   // Read mux: every cycle from the current address, registered for the bus
   always_comb begin
      rdata_d = '0;
      if (bus.address == c_A_PRESC) begin
         rdata_d[15:0] = presc_q;
      end else if (bus.address == c_A_PEND) begin
         rdata_d[NUM_CH-1:0] = to_q;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_ch == CH_W'(c)) begin
               case (w_off)
                  c_OFF_STAT: rdata_d[1:0]       = {state_q[c] == S_RUN, to_q[c]};
                  c_OFF_CTRL: rdata_d[1:0]       = {cont_q[c], ito_q[c]};
                  c_OFF_PER:  rdata_d[CNT_W-1:0] = period_q[c];
                  default:    rdata_d[CNT_W-1:0] = snap_q[c];
               endcase
            end
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= '{default: S_IDLE};
         cnt_q    <= '{default: c_RST_VAL};
         period_q <= '{default: c_RST_VAL};
         snap_q   <= '{default: '0};
         to_q     <= '0;
         ito_q    <= '0;
         cont_q   <= '0;
         load_q   <= '0;
         presc_q  <= '0;
         pcnt_q   <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         snap_q   <= snap_d;
         to_q     <= to_d;
         ito_q    <= ito_d;
         cont_q   <= cont_d;
         load_q   <= load_d;
         presc_q  <= presc_d;
         pcnt_q   <= pcnt_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule
`default_nettype wire
